transmitter_calc: RTL and testbench

//  Top-level UART message sender for the calculator frame on Arty A7-35T (100 MHz).

---
 rtl/calc_pkg.sv | 21 ++
 rtl/uart_tx.sv | 102 ++++++++++
 rtl/transmitter_calc.sv | 88 ++++++++
 tb/tb_transmitter_calc.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants, FSM state types and the default message for the calculator UART sender.
// Imported by transmitter_calc and uart_tx.
package calc_pkg;

    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 9600;
    localparam int MSG_W    = 128;

    localparam logic [MSG_W-1:0] MSG = "Calculator ready";

    // Rounded to the nearest whole clock so the line rate error stays below half a clock per bit.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, DONE} calc_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, N data bits LSB first, one stop bit, each CLKS_PER_BIT clocks.
// tx_done pulses for one cycle after the stop bit; tx_start is ignored while busy.
module uart_tx #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = calc_pkg::CLKS_PER_BIT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tx_start,
    input  logic [N-1:0] tx_data,
    output logic         tx_busy,
    output logic         tx_done,
    output logic         txd
);
    import calc_pkg::*;

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (N > 1) ? $clog2(N) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N - 1);

    tx_state_t         state, state_d;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_d;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [N-1:0]      shift, shift_d;
    logic              txd_d, tx_done_d;
    logic              bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign tx_busy = (state != TX_IDLE);

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt + 1'b1;
        bit_cnt_d  = bit_cnt;
        shift_d    = shift;
        txd_d      = txd;
        tx_done_d  = 1'b0;
        case (state)
            TX_IDLE: begin
                baud_cnt_d = '0;
                if (tx_start) begin
                    state_d = TX_START;
                    shift_d = tx_data;
                    txd_d   = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d    = TX_DATA;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    txd_d      = shift[0];
                    shift_d    = shift >> 1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_d = TX_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                        txd_d     = shift[0];
                        shift_d   = shift >> 1;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    state_d    = TX_IDLE;
                    baud_cnt_d = '0;
                    tx_done_d  = 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_cnt_d;
            bit_cnt  <= bit_cnt_d;
            shift    <= shift_d;
            txd      <= txd_d;
            tx_done  <= tx_done_d;
        end
    end

endmodule

// File: rtl/transmitter_calc.sv
// Sends the fixed M-bit message once after reset, MSB character first, through uart_tx.
// LEDs: [0] frame busy, [1] frame done, [2] byte in flight, [3] inverted line.
module transmitter_calc #(
    parameter int           N        = 8,
    parameter int           M        = calc_pkg::MSG_W,
    parameter int           CLK_FREQ = calc_pkg::CLK_FREQ,
    parameter int           BAUD     = calc_pkg::BAUD,
    parameter logic [M-1:0] MSG      = calc_pkg::MSG
) (
    input  logic       clk,
    input  logic       reset,
    output logic       txd_pin,
    output logic [3:0] led
);
    import calc_pkg::*;

    localparam int NCHAR    = M / N;
    localparam int IDX_W    = (NCHAR > 1) ? $clog2(NCHAR) : 1;
    localparam int BIT_CLKS = clks_per_bit(CLK_FREQ, BAUD);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHAR - 1);

    calc_state_t      state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [N-1:0]     tx_byte, tx_byte_d;
    logic             tx_start, tx_busy, tx_done, txd;

    uart_tx #(
        .N            (N),
        .CLKS_PER_BIT (BIT_CLKS)
    ) u_uart_tx (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_byte),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .txd      (txd)
    );

    assign txd_pin = txd;

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        tx_byte_d = tx_byte;
        tx_start  = 1'b0;
        case (state)
            IDLE: state_d = LOAD;
            LOAD: begin
                tx_byte_d = MSG[M-1-N*int'(idx) -: N];
                state_d   = SEND;
            end
            SEND: begin
                tx_start = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                // The index stops at the last character rather than wrapping.
                if (tx_done) begin
                    if (idx == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            tx_byte <= '0;
            led     <= 4'b0000;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            tx_byte <= tx_byte_d;
            led     <= {~txd, tx_busy, (state_d == DONE), (state_d inside {LOAD, SEND, WAIT})};
        end
    end

endmodule

// File: tb/tb_transmitter_calc.sv
// Self-checking bench for transmitter_calc using 4 clocks per bit so whole frames fit in a short run.
// A per-cycle line model plus an independent mid-bit UART decoder check the serial output and LEDs.
module tb_transmitter_calc;

    localparam int N          = 8;
    localparam int M          = 128;
    localparam int NCHAR      = M / N;
    localparam int CLK_FREQ   = 100_000_000;
    localparam int BAUD       = CLK_FREQ / 4;
    localparam int CPB        = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int FIRST_IDLE = 2;   // idle samples between reset release and the first start bit
    localparam int GAP_IDLE   = 3;   // idle samples between a stop bit and the next start bit
    localparam int TAIL       = 40;

    localparam logic [M-1:0] MSG_BITS = "Calculator ready";

    string msg = "Calculator ready";

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       txd_pin;
    logic [3:0] led;

    int checks = 0;
    int errors = 0;

    bit exp_txd[$];
    bit exp_in[$];
    bit cap[$];

    transmitter_calc #(
        .N        (N),
        .M        (M),
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .MSG      (MSG_BITS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .txd_pin (txd_pin),
        .led     (led)
    );

    always #5 clk = ~clk;

    task automatic push_level(input bit v, input bit in_char, input int n);
        repeat (n) begin
            exp_txd.push_back(v);
            exp_in.push_back(in_char);
        end
    endtask

    // Expected line level for every sample after reset release, built straight from the 8N1 framing.
    task automatic build_model();
        byte b;
        exp_txd.delete();
        exp_in.delete();
        push_level(1'b1, 1'b0, FIRST_IDLE);
        for (int c = 0; c < NCHAR; c++) begin
            b = msg[c];
            push_level(1'b0, 1'b1, CPB);
            for (int k = 0; k < N; k++) push_level(b[k], 1'b1, CPB);
            push_level(1'b1, 1'b1, CPB);
            if (c < NCHAR - 1) push_level(1'b1, 1'b0, GAP_IDLE);
        end
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) begin
            @(negedge clk);
            checks++;
            if (txd_pin !== 1'b1 || led !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold: txd_pin=%b led=%b, required txd_pin=1 led=0000", txd_pin, led);
            end
        end
        reset = 1'b0;
    endtask

    task automatic run_compare(input int ncyc);
        bit e, in_now, in_prev, e_prev;
        int sz;
        sz     = exp_txd.size();
        e_prev = 1'b1;
        cap.delete();
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            e       = (t < sz) ? exp_txd[t] : 1'b1;
            in_now  = (t < sz) ? exp_in[t] : 1'b0;
            in_prev = (t > 0 && t - 1 < sz) ? exp_in[t-1] : 1'b0;
            checks++;
            if (txd_pin !== e) begin
                errors++;
                $display("FAIL txd_line t=%0d: got %b, expected %b", t, txd_pin, e);
            end
            checks++;
            if (led[3] !== ~e_prev) begin
                errors++;
                $display("FAIL led3_inv_txd t=%0d: got %b, expected %b", t, led[3], ~e_prev);
            end
            checks++;
            if (led[2] !== in_prev) begin
                errors++;
                $display("FAIL led2_byte_busy t=%0d: got %b, expected %b", t, led[2], in_prev);
            end
            if (in_now) begin
                checks++;
                if (led[1:0] !== 2'b01) begin
                    errors++;
                    $display("FAIL led_frame_busy t=%0d: got led[1:0]=%b, expected 01", t, led[1:0]);
                end
            end
            if (t >= sz + 2) begin
                checks++;
                if (led !== 4'b0010) begin
                    errors++;
                    $display("FAIL led_done t=%0d: got %b, expected 0010", t, led);
                end
            end
            cap.push_back(txd_pin);
            e_prev = e;
        end
    endtask

    // Independent receiver: find falling edges and sample each bit in its middle.
    task automatic decode_and_check();
        byte got[$];
        byte v;
        int  i;
        i = 1;
        while (i + 10 * CPB <= cap.size()) begin
            if (cap[i-1] && !cap[i]) begin
                for (int k = 0; k < N; k++) v[k] = cap[i + CPB/2 + (k + 1) * CPB];
                checks++;
                if (cap[i + CPB/2 + 9 * CPB] !== 1'b1) begin
                    errors++;
                    $display("FAIL stop_bit char=%0d: got 0, expected 1", got.size());
                end
                got.push_back(v);
                i += 10 * CPB;
            end else begin
                i++;
            end
        end
        checks++;
        if (got.size() != NCHAR) begin
            errors++;
            $display("FAIL byte_count: got %0d, expected %0d", got.size(), NCHAR);
        end
        for (int c = 0; c < NCHAR && c < got.size(); c++) begin
            checks++;
            if (got[c] !== msg[c]) begin
                errors++;
                $display("FAIL decoded_char[%0d]: got 0x%02h, expected 0x%02h", c, got[c], msg[c]);
            end
        end
    endtask

    task automatic test_reset();
        apply_reset(5);
    endtask

    task automatic test_frame();
        run_compare(exp_txd.size() + TAIL);
        decode_and_check();
    endtask

    task automatic test_done_hold();
        repeat (200) begin
            @(negedge clk);
            checks++;
            if (txd_pin !== 1'b1 || led !== 4'b0010) begin
                errors++;
                $display("FAIL done_hold: txd_pin=%b led=%b, expected txd_pin=1 led=0010", txd_pin, led);
            end
        end
    endtask

    task automatic test_mid_reset();
        int char5_start, off;
        char5_start = FIRST_IDLE + 5 * (10 * CPB + GAP_IDLE);
        off         = $urandom_range(0, 10 * CPB - 1);
        apply_reset(3);
        run_compare(char5_start + off);
        apply_reset(3);
        test_frame();
    endtask

    task automatic test_back_to_back();
        repeat (4) begin
            apply_reset($urandom_range(1, 4));
            run_compare($urandom_range(1, exp_txd.size()));
        end
        apply_reset(1);
        test_frame();
    endtask

    initial begin
        build_model();
        test_reset();
        test_frame();
        test_done_hold();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
